// File: rtl/serial_mult_param_pkg.sv
// Shared types and sizing helpers for the parametrised serial multiplier.
package serial_mult_param_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        CALC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Number of CALC edges needed to consume the whole multiplier.
    function automatic int calc_cycles(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter must hold the full cycle count, not just count down to it.
    function automatic int cnt_width(input int width, input int digit);
        return $clog2(width / digit + 1);
    endfunction

endpackage

// File: rtl/serial_mult_param_if.sv
// Put/get register interface of the serial multiplier.
interface serial_mult_param_if #(
    parameter int WIDTH = 8
);
    logic                 put;
    logic [WIDTH-1:0]     idata;
    logic                 is_signed;
    logic                 get;
    logic                 ready;
    logic                 busy;
    logic                 result_valid;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output put, idata, is_signed, get,
        input  ready, busy, result_valid, result
    );

    modport slave (
        input  put, idata, is_signed, get,
        output ready, busy, result_valid, result
    );
endinterface

// File: rtl/serial_mult_param.sv
// Serial shift-and-add multiplier: WIDTH-bit operands, DIGIT multiplier bits per cycle,
// optional two's-complement mode via magnitude multiply plus final negation.
module serial_mult_param
    import serial_mult_param_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic               clk,
    input  logic               rst_b,
    serial_mult_param_if.slave bus
);

    localparam int CYCLES = calc_cycles(WIDTH, DIGIT);
    localparam int CNT_W  = cnt_width(WIDTH, DIGIT);
    localparam int PW     = 2 * WIDTH;

    if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4)) begin : g_bad_digit
        $error("serial_mult_param: DIGIT must be 1, 2 or 4");
    end
    if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_width
        $error("serial_mult_param: WIDTH must be >=2 and divisible by DIGIT");
    end

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    state_t           state_q, state_d;
    logic [PW-1:0]    a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             a_neg_q, a_neg_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    partial;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.put) state_d = LOAD_B;
            LOAD_B:  if (bus.put) state_d = CALC;
            CALC:    if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    if (bus.get) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready        = (state_q == IDLE) || (state_q == LOAD_B);
        bus.busy         = (state_q == CALC);
        bus.result_valid = (state_q == DONE);
        bus.result       = result_q;
    end

    // The multiplicand is pre-shifted each step so the partial product needs no variable shift.
    assign partial = a_sh_q * {{(PW-DIGIT){1'b0}}, b_q[DIGIT-1:0]};

    always_comb begin
        a_sh_d   = a_sh_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        sgn_d    = sgn_q;
        a_neg_d  = a_neg_q;
        neg_d    = neg_q;
        unique case (state_q)
            IDLE: if (bus.put) begin
                a_sh_d  = {{WIDTH{1'b0}}, mag(bus.idata, bus.is_signed)};
                a_neg_d = bus.is_signed & bus.idata[WIDTH-1];
                sgn_d   = bus.is_signed;
            end
            LOAD_B: if (bus.put) begin
                b_d   = mag(bus.idata, sgn_q);
                neg_d = a_neg_q ^ (sgn_q & bus.idata[WIDTH-1]);
                cnt_d = CNT_W'(CYCLES);
                acc_d = '0;
            end
            CALC: begin
                acc_d  = acc_q + partial;
                a_sh_d = a_sh_q << DIGIT;
                b_d    = b_q >> DIGIT;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1))
                    result_d = neg_q ? (~acc_d + 1'b1) : acc_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            a_sh_q   <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            sgn_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            sgn_q    <= sgn_d;
            a_neg_q  <= a_neg_d;
            neg_q    <= neg_d;
        end
    end

endmodule

// File: tb/tb_serial_mult_param.sv
// Directed self-checking bench for serial_mult_param in three WIDTH/DIGIT configurations.
module tb_serial_mult_param;

    logic clk;
    logic rst_b;
    int   pass_cnt;
    int   total_cnt;

    serial_mult_param_if #(.WIDTH(8))  if1 ();
    serial_mult_param_if #(.WIDTH(8))  if2 ();
    serial_mult_param_if #(.WIDTH(16)) if3 ();

    serial_mult_param #(.WIDTH(8),  .DIGIT(1)) u_dut1 (.clk(clk), .rst_b(rst_b), .bus(if1.slave));
    serial_mult_param #(.WIDTH(8),  .DIGIT(2)) u_dut2 (.clk(clk), .rst_b(rst_b), .bus(if2.slave));
    serial_mult_param #(.WIDTH(16), .DIGIT(4)) u_dut3 (.clk(clk), .rst_b(rst_b), .bus(if3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else begin
            pass_cnt++;
            $display("check %s: %h ok", name, act);
        end
    endtask

    task automatic do_put(input logic [7:0] d, input logic s);
        @(negedge clk);
        if1.put = 1'b1; if1.idata = d; if1.is_signed = s;
        @(posedge clk); #1;
        if1.put = 1'b0;
    endtask

    task automatic do_get();
        @(negedge clk);
        if1.get = 1'b1;
        @(posedge clk); #1;
        if1.get = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!if1.result_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          output logic [15:0] res, output int lat);
        do_put(a, s);
        do_put(b, 1'b0);
        wait_valid(lat);
        res = if1.result;
        $display("op a=%h b=%h signed=%0b -> %h after %0d edges", a, b, s, res, lat);
    endtask

    task automatic test_reset();
        logic [15:0] res;
        int lat;
        repeat (2) @(posedge clk); #1;
        chk("reset_ready", 32'(if1.ready), 32'd1);
        chk("reset_busy", 32'(if1.busy), 32'd0);
        chk("reset_valid", 32'(if1.result_valid), 32'd0);
        chk("reset_result", 32'(if1.result), 32'd0);
        @(negedge clk); rst_b = 1'b1;
        run_op(8'd3, 8'd4, 1'b0, res, lat);
        chk("pre_reset_op", 32'(res), 32'd12);
        do_get();
        do_put(8'd5, 1'b0);
        do_put(8'd5, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_b = 1'b0;
        #1;
        chk("midcalc_ready", 32'(if1.ready), 32'd1);
        chk("midcalc_busy", 32'(if1.busy), 32'd0);
        chk("midcalc_valid", 32'(if1.result_valid), 32'd0);
        chk("midcalc_result", 32'(if1.result), 32'd0);
        @(negedge clk); rst_b = 1'b1;
        run_op(8'd2, 8'd3, 1'b0, res, lat);
        chk("post_reset_op", 32'(res), 32'd6);
        do_get();
    endtask

    task automatic test_unsigned();
        logic [15:0] res;
        int lat;
        run_op(8'd5, 8'd5, 1'b0, res, lat);
        chk("u5x5_latency", 32'(lat), 32'd8);
        chk("u5x5_result", 32'(res), 32'd25);
        repeat (3) @(posedge clk); #1;
        chk("u5x5_held_valid", 32'(if1.result_valid), 32'd1);
        chk("u5x5_held_result", 32'(if1.result), 32'd25);
        do_get();
        chk("u5x5_get_valid", 32'(if1.result_valid), 32'd0);
        chk("u5x5_get_ready", 32'(if1.ready), 32'd1);
        chk("u5x5_kept_result", 32'(if1.result), 32'd25);
    endtask

    task automatic test_signed();
        logic [7:0]  va [5] = '{8'hFD, 8'h80, 8'h80, 8'hFF, 8'hFF};
        logic [7:0]  vb [5] = '{8'h05, 8'h80, 8'h80, 8'hFF, 8'hFF};
        logic        vs [5] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
        logic [15:0] ve [5] = '{16'hFFF1, 16'h4000, 16'h4000, 16'hFE01, 16'h0001};
        logic [15:0] res;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vs[i], res, lat);
            chk($sformatf("signed_vec%0d", i), 32'(res), 32'(ve[i]));
            do_get();
        end
    endtask

    task automatic test_digit();
        int lat;
        @(negedge clk);
        if2.put = 1'b1; if2.idata = 8'hFF; if2.is_signed = 1'b0;
        if3.put = 1'b1; if3.idata = 16'hFFFF; if3.is_signed = 1'b0;
        @(negedge clk);
        if3.idata = 16'h0002;
        @(posedge clk); #1;
        if2.put = 1'b0; if3.put = 1'b0;
        lat = 0;
        while (!(if2.result_valid && if3.result_valid) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 4) begin
                chk("d2_valid_at4", 32'(if2.result_valid), 32'd1);
                chk("d4_valid_at4", 32'(if3.result_valid), 32'd1);
            end
        end
        chk("d2_latency", 32'(lat), 32'd4);
        chk("d2_result", 32'(if2.result), 32'h0000_FE01);
        chk("d4_result", if3.result, 32'h0001_FFFE);
        @(negedge clk); if2.get = 1'b1; if3.get = 1'b1;
        @(posedge clk); #1; if2.get = 1'b0; if3.get = 1'b0;
    endtask

    task automatic test_protocol();
        logic [15:0] res;
        int lat;
        // put held for three cycles: 7, 3, then 9 must be dropped
        @(negedge clk); if1.put = 1'b1; if1.idata = 8'd7; if1.is_signed = 1'b0;
        @(negedge clk); if1.idata = 8'd3;
        @(negedge clk); if1.idata = 8'd9;
        @(posedge clk); #1;
        chk("held_put_busy", 32'(if1.busy), 32'd1);
        if1.put = 1'b0;
        wait_valid(lat);
        chk("held_put_result", 32'(if1.result), 32'd21);
        do_get();
        // get during CALC has no effect
        do_put(8'd6, 1'b0);
        do_put(8'd7, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); if1.get = 1'b1;
        @(posedge clk); #1; if1.get = 1'b0;
        chk("calc_get_busy", 32'(if1.busy), 32'd1);
        wait_valid(lat);
        chk("calc_get_result", 32'(if1.result), 32'd42);
        // put+get together in DONE: get wins, operand dropped
        @(negedge clk); if1.put = 1'b1; if1.get = 1'b1; if1.idata = 8'hAA;
        @(posedge clk); #1; if1.put = 1'b0; if1.get = 1'b0;
        chk("putget_valid", 32'(if1.result_valid), 32'd0);
        chk("putget_ready", 32'(if1.ready), 32'd1);
        run_op(8'd2, 8'd3, 1'b0, res, lat);
        chk("putget_next_op", 32'(res), 32'd6);
        chk("putget_latency", 32'(lat), 32'd8);
        do_get();
        // is_signed after A is ignored
        do_put(8'hFF, 1'b0);
        do_put(8'hFF, 1'b1);
        wait_valid(lat);
        chk("late_signed", 32'(if1.result), 32'h0000_FE01);
        do_get();
    endtask

    task automatic test_back_to_back();
        logic [15:0] res;
        int lat;
        run_op(8'd12, 8'd11, 1'b0, res, lat);
        chk("b2b_first", 32'(res), 32'd132);
        do_get();
        run_op(8'hFE, 8'h03, 1'b1, res, lat);
        chk("b2b_second", 32'(res), 32'hFFFA);
        chk("b2b_latency", 32'(lat), 32'd8);
        do_get();
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst_b = 1'b0;
        if1.put = 1'b0; if1.get = 1'b0; if1.idata = '0; if1.is_signed = 1'b0;
        if2.put = 1'b0; if2.get = 1'b0; if2.idata = '0; if2.is_signed = 1'b0;
        if3.put = 1'b0; if3.get = 1'b0; if3.idata = '0; if3.is_signed = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_digit();
        test_protocol();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
